// File: rtl/pulse_pkg.sv
// Shared helpers for the pulse extender / compressor family.
package pulse_pkg;

   // Number of bits needed to hold the unsigned value `value` (minimum 1).
   function automatic int bit_len(input int value);
      int n;
      n = 1;
      for (int i = 1; i < 32; i++) begin
         if ((value >> i) != 0) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/pulse_compressor_lane.sv
// One lane of the pulse compressor: input synchronizer, stability filter that
// accepts a new level only after CYCLES consecutive synchronized cycles, and
// registered one-cycle rise/fall strobes on each accepted transition.
module pulse_compressor_lane
   import pulse_pkg::*;
#(
   parameter int CYCLES      = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic signal_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int                 BIT_LEN = bit_len(CYCLES);
   localparam logic [BIT_LEN-1:0] LAST    = BIT_LEN'(CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic [BIT_LEN-1:0]     count_d, count_q;
   logic                   level_d, level_q;
   logic                   rise_d, rise_q;
   logic                   fall_d, fall_q;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   // Shift the raw input through the synchronizer chain; stage 0 is the sampler.
   always_comb begin
      sync_d[0] = signal_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Stability filter: count cycles of disagreement, accept at CYCLES-1.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      count_d = count_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync == level_q) begin
         // Any return to the accepted level discards the partial count.
         count_d = '0;
      end else if (count_q == LAST) begin
         level_d = sync;
         count_d = '0;
         rise_d  = sync;
         fall_d  = ~sync;
      end else begin
         count_d = count_q + BIT_LEN'(1);
      end
   end

   // State registers with synchronous reset; everything clears to 0.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (reset) begin
         sync_q  <= '0;
         count_q <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         count_q <= count_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/pulse_compressor.sv
// Pulse compressor: WIDTH independent lanes turning slow, stretched or bouncy
// level inputs into a debounced level plus one-cycle rise/fall event strobes.
module pulse_compressor
   import pulse_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int CYCLES      = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] signal_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   // One self-contained lane per input bit; lanes never interact.
   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      pulse_compressor_lane #(
         .CYCLES      (CYCLES),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .signal_i (signal_i[g]),
         .level_o  (level_o[g]),
         .rise_o   (rise_o[g]),
         .fall_o   (fall_o[g])
      );
   end

endmodule

// File: tb/tb_pulse_compressor.sv
// Directed bench for pulse_compressor with a strobe scoreboard per DUT.
module tb_pulse_compressor;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sig_a, level_a, rise_a, fall_a;
   logic [0:0] sig_b, level_b, rise_b, fall_b;

   always #5 clk = ~clk;

   // Four lanes, CYCLES=4, SYNC_STAGES=2
   pulse_compressor #(.WIDTH(4), .CYCLES(4), .SYNC_STAGES(2)) dut_a (
      .clk      (clk),
      .reset    (reset),
      .signal_i (sig_a),
      .level_o  (level_a),
      .rise_o   (rise_a),
      .fall_o   (fall_a)
   );

   // Single lane, CYCLES=1 boundary
   pulse_compressor #(.WIDTH(1), .CYCLES(1), .SYNC_STAGES(2)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .signal_i (sig_b),
      .level_o  (level_b),
      .rise_o   (rise_b),
      .fall_o   (fall_b)
   );

   int ecnt   = 0;
   int n_vec  = 0;
   int n_miss = 0;

   always @(posedge clk) ecnt <= ecnt + 1;

   typedef struct {
      int         stamp;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] level;
   } ev_t;

   ev_t q_a[$];
   ev_t q_b[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_a(input int stamp, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
      ev_t e;
      e.stamp = stamp; e.rise = r; e.fall = f; e.level = l;
      q_a.push_back(e);
   endtask

   task automatic expect_b(input int stamp, input logic r, input logic f, input logic l);
      ev_t e;
      e.stamp = stamp; e.rise = {3'b0, r}; e.fall = {3'b0, f}; e.level = {3'b0, l};
      q_b.push_back(e);
   endtask

   // Monitor A: every strobe must match the next expected event (cycle and values)
   always @(negedge clk) begin : mon_a
      ev_t e;
      if ((rise_a | fall_a) != 4'b0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_strobe", {32'(ecnt), rise_a, fall_a, level_a}, 64'd0);
         end else begin
            e = q_a.pop_front();
            check("a_event", {32'(ecnt), rise_a, fall_a, level_a},
                  {32'(e.stamp), e.rise, e.fall, e.level});
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin : mon_b
      ev_t e;
      if ((rise_b | fall_b) != 1'b0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_strobe", {32'(ecnt), rise_b, fall_b, level_b}, 64'd0);
         end else begin
            e = q_b.pop_front();
            check("b_event", {32'(ecnt), 3'b0, rise_b, 3'b0, fall_b, 3'b0, level_b},
                  {32'(e.stamp), e.rise, e.fall, e.level});
         end
      end
   end

   logic bounce [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      int n;
      reset = 1'b1;
      sig_a = 4'b0;
      sig_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", {level_a, rise_a, fall_a}, 64'd0);
      check("reset_b", {level_b, rise_b, fall_b}, 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Clean rise on lane 0: update at E6
      n = ecnt;
      sig_a[0] = 1'b1;
      expect_a(n + 6, 4'b0001, 4'b0000, 4'b0001);
      repeat (5) @(negedge clk);
      check("rise_level_before_e6", level_a, 64'h0);
      @(negedge clk);
      check("rise_level_at_e6", level_a, 64'h1);
      repeat (4) @(negedge clk);

      // Glitch on lane 1: 3 cycles high, rejected
      sig_a[1] = 1'b1;
      repeat (3) @(negedge clk);
      sig_a[1] = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_level", level_a, 64'h1);

      // Bounce on lane 0 from level 1: one fall at n+9
      n = ecnt;
      expect_a(n + 9, 4'b0000, 4'b0001, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         sig_a[0] = bounce[i];
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("bounce_level", level_a, 64'h0);

      // Multi-lane: lane 0 at E1, lane 2 at E3
      n = ecnt;
      sig_a[0] = 1'b1;
      expect_a(n + 6, 4'b0001, 4'b0000, 4'b0001);
      repeat (2) @(negedge clk);
      sig_a[2] = 1'b1;
      expect_a(n + 8, 4'b0100, 4'b0000, 4'b0101);
      repeat (10) @(negedge clk);
      check("multi_level", level_a, 64'h5);

      // Both lanes fall on the same edge
      n = ecnt;
      sig_a = 4'b0000;
      expect_a(n + 6, 4'b0000, 4'b0101, 4'b0000);
      repeat (10) @(negedge clk);
      check("dual_fall_level", level_a, 64'h0);

      // Reset at E4 mid-count: partial count discarded, first non-reset edge n+5
      n = ecnt;
      sig_a[0] = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_state", {level_a, rise_a, fall_a, level_b}, 64'd0);
      reset = 1'b0;
      expect_a(n + 10, 4'b0001, 4'b0000, 4'b0001);
      repeat (12) @(negedge clk);
      check("post_reset_level", level_a, 64'h1);

      // CYCLES=1: single-cycle pulse gives rise at E3, fall at E4
      n = ecnt;
      sig_b = 1'b1;
      expect_b(n + 3, 1'b1, 1'b0, 1'b1);
      expect_b(n + 4, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      sig_b = 1'b0;
      repeat (6) @(negedge clk);
      check("c1_level", level_b, 64'h0);

      check("q_a_drained", q_a.size(), 64'd0);
      check("q_b_drained", q_b.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
